// File: rtl/sub_serial_if.sv
// Handshake and operand/result bundle for sub_serial.
// Port Ov is present only when SUB_SERIAL_OVF_EN is defined.
interface sub_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bo;
`ifdef SUB_SERIAL_OVF_EN
    logic             Ov;
`endif

    modport master (
        output in_valid, A, B, Bi, out_ready,
        input  in_ready, out_valid, D, Bo
`ifdef SUB_SERIAL_OVF_EN
        , input Ov
`endif
    );

    modport slave (
        input  in_valid, A, B, Bi, out_ready,
        output in_ready, out_valid, D, Bo
`ifdef SUB_SERIAL_OVF_EN
        , output Ov
`endif
    );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial full subtractor computing A - B - Bi one bit per clock, LSB first.
// Define SUB_SERIAL_OVF_EN to add the registered signed-overflow output Ov.
module sub_serial #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    sub_serial_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
`ifdef SUB_SERIAL_OVF_EN
    logic             r_sa;
    logic             r_sb;
    logic             r_ov;
`endif

    logic w_a;
    logic w_b;
    logic w_d;
    logic w_br;

    assign w_a  = r_a[0];
    assign w_b  = r_b[0];
    assign w_d  = w_a ^ w_b ^ r_br;
    assign w_br = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_ov    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_br    <= bus.Bi;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
`ifdef SUB_SERIAL_OVF_EN
                        r_sa    <= bus.A[WIDTH-1];
                        r_sb    <= bus.B[WIDTH-1];
`endif
                    end
                end
                S_CALC: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br;
                    // Difference bits enter at the MSB so D is aligned after WIDTH steps.
                    r_d   <= {w_d, r_d[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
`ifdef SUB_SERIAL_OVF_EN
                        r_ov    <= (r_sa ^ r_sb) & (w_d ^ r_sa);
`endif
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.D         = r_d;
    // The borrow register holds the final borrow once the last bit is processed.
    assign bus.Bo        = r_br;
`ifdef SUB_SERIAL_OVF_EN
    assign bus.Ov        = r_ov;
`endif
endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial (WIDTH = 8) against an arithmetic reference model.
// Overflow cases run when SUB_SERIAL_OVF_EN is defined.
module tb_sub_serial;
    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   acc_cyc;
    int   rmode;
    exp_t sb[$];

    sub_serial_if #(.WIDTH(8)) bus ();

    sub_serial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // out_ready: 0 -> always 1, 1 -> random, otherwise held low.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic bi);
        exp_t e;
        int   diff;
        diff = int'(a) - int'(b) - int'(bi);
        e.d  = 8'(diff);
        e.bo = (diff < 0);
        e.ov = (a[7] != b[7]) && (e.d[7] != a[7]);
        return e;
    endfunction

    // Monitor: accept timing, output latency, and result comparison at handshake.
    initial begin
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        acc_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
                continue;
            end
            if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
            if (bus.out_valid && !prev_ov) chk("latency", 32'(cyc - acc_cyc), 32'd8);
            prev_ov = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got D=%0h, expected no result", bus.D);
                end else begin
                    e = sb.pop_front();
                    chk("D", 32'(bus.D), 32'(e.d));
                    chk("Bo", 32'(bus.Bo), 32'(e.bo));
`ifdef SUB_SERIAL_OVF_EN
                    chk("Ov", 32'(bus.Ov), 32'(e.ov));
`endif
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input exp_t e);
        bit ok;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.A        = a;
        bus.B        = b;
        bus.Bi       = bi;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = 8'($urandom);
        bus.B        = 8'($urandom);
        bus.Bi       = 1'($urandom);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic bi,
                            input logic [7:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.ov = ov;
        send(a, b, bi, e);
        drain();
    endtask

    initial begin
        logic [7:0] held_d;
        logic       held_bo;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;
        bit         seen;
        n_vec        = 0;
        n_err        = 0;
        rmode        = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.Bi       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_D", 32'(bus.D), 32'd0);
        chk("rst_Bo", 32'(bus.Bo), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        directed(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        directed(8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0);
        directed(8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0);
`ifdef SUB_SERIAL_OVF_EN
        directed(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        directed(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
`endif

        // Back-pressure: result held in DONE while a new request waits.
        rmode = 2;
        send(8'hA7, 8'h5C, 1'b0, model(8'hA7, 8'h5C, 1'b0));
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_out_valid_seen", 32'(seen), 32'd1);
        held_d  = bus.D;
        held_bo = bus.Bo;
        bus.A        = 8'h44;
        bus.B        = 8'h45;
        bus.Bi       = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_D", 32'(bus.D), 32'(held_d));
            chk("bp_Bo", 32'(bus.Bo), 32'(held_bo));
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        rmode = 0;
        send(8'h44, 8'h45, 1'b0, model(8'h44, 8'h45, 1'b0));
        drain();

        // Reset after three CALC cycles discards the partial result.
        send(8'h5A, 8'h33, 1'b0, model(8'h5A, 8'h33, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_D", 32'(bus.D), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        directed(8'h22, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0);

        rmode = 1;
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            send(ra, rb, rbi, model(ra, rb, rbi));
            drain();
        end
        rmode = 0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
